// File: rtl/sys_array_sched.sv
// Tile scheduler for the systolic PE array: weight load, activation streaming, psum drain.
// Optional performance counters are built when SYS_SCHED_PERF_EN is defined.
module sys_array_sched #(
  parameter int ARRAY_N = 32,
  parameter int ACT_W   = 10,
  parameter int TILE_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [TILE_W-1:0]          n_tiles,
  input  logic [ACT_W-1:0]           act_len,
  input  logic                       in_stall,
  output logic                       busy,
  output logic                       done,
  output logic                       w_ps,
  output logic                       w_load,
  output logic                       act_valid,
  output logic                       psum_capture,
  output logic [$clog2(ARRAY_N)-1:0] w_rd_addr,
  output logic [ACT_W-1:0]           act_rd_addr,
  output logic [TILE_W-1:0]          tile_idx
`ifdef SYS_SCHED_PERF_EN
  ,
  output logic [31:0]                perf_busy_cyc,
  output logic [31:0]                perf_stall_cyc
`endif
);

  localparam int AW        = $clog2(ARRAY_N);
  localparam int DRAIN_LEN = 2 * ARRAY_N - 1;
  localparam int CNT_W     = ($clog2(2 * ARRAY_N) > ACT_W) ? $clog2(2 * ARRAY_N) : ACT_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TILE_W-1:0]  tile_q, tile_d;
  logic [TILE_W-1:0]  n_tiles_q, n_tiles_d;
  logic [ACT_W-1:0]   act_len_q, act_len_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               w_ps_q, w_ps_d;
  logic               w_load_q, w_load_d;
  logic               act_valid_q, act_valid_d;
  logic               psum_capture_q, psum_capture_d;
  logic [AW-1:0]      w_rd_addr_q, w_rd_addr_d;
  logic [ACT_W-1:0]   act_rd_addr_q, act_rd_addr_d;

  logic               active;
  logic               done_now;

  // A LOAD_W/COMPUTE cycle only counts when its strobe is high; a low strobe is a stall bubble.
  assign active = w_load_q | act_valid_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tile_d    = tile_q;
    n_tiles_d = n_tiles_q;
    act_len_d = act_len_q;
    done_now  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n_tiles != '0) begin
            n_tiles_d = n_tiles;
            act_len_d = act_len;
            tile_d    = '0;
            state_d   = S_LOAD_W;
          end else begin
            done_now = 1'b1;
          end
        end
      end
      S_LOAD_W: begin
        if (active) begin
          if (cnt_q == CNT_W'(ARRAY_N - 1)) begin
            state_d = (act_len_q == '0) ? S_DRAIN : S_COMPUTE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (active) begin
          if (cnt_q == CNT_W'(act_len_q) - CNT_W'(1)) begin
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
          if (tile_q == n_tiles_q - TILE_W'(1)) begin
            state_d = S_DONE;
          end else begin
            tile_d  = tile_q + TILE_W'(1);
            state_d = S_LOAD_W;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    // Outputs for the coming cycle, decoded from next state/counter; in_stall turns it into a bubble.
    busy_d         = (state_d != S_IDLE);
    done_d         = done_now | (state_d == S_DONE);
    w_ps_d         = (state_d == S_COMPUTE) | (state_d == S_DRAIN);
    w_load_d       = (state_d == S_LOAD_W) & ~in_stall;
    act_valid_d    = (state_d == S_COMPUTE) & ~in_stall;
    psum_capture_d = (state_d == S_DRAIN) & (cnt_d >= CNT_W'(ARRAY_N - 1));
    w_rd_addr_d    = w_load_d ? cnt_d[AW-1:0] : w_rd_addr_q;
    act_rd_addr_d  = act_valid_d ? cnt_d[ACT_W-1:0] : act_rd_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      tile_q         <= '0;
      n_tiles_q      <= '0;
      act_len_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      w_ps_q         <= 1'b0;
      w_load_q       <= 1'b0;
      act_valid_q    <= 1'b0;
      psum_capture_q <= 1'b0;
      w_rd_addr_q    <= '0;
      act_rd_addr_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tile_q         <= tile_d;
      n_tiles_q      <= n_tiles_d;
      act_len_q      <= act_len_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      w_ps_q         <= w_ps_d;
      w_load_q       <= w_load_d;
      act_valid_q    <= act_valid_d;
      psum_capture_q <= psum_capture_d;
      w_rd_addr_q    <= w_rd_addr_d;
      act_rd_addr_q  <= act_rd_addr_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign w_ps         = w_ps_q;
  assign w_load       = w_load_q;
  assign act_valid    = act_valid_q;
  assign psum_capture = psum_capture_q;
  assign w_rd_addr    = w_rd_addr_q;
  assign act_rd_addr  = act_rd_addr_q;
  assign tile_idx     = tile_q;

`ifdef SYS_SCHED_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;
  logic        start_accept;
  logic        bubble;

  assign start_accept = (state_q == S_IDLE) & start;
  assign bubble       = ((state_q == S_LOAD_W) | (state_q == S_COMPUTE)) & ~active;

  always_ff @(posedge clk) begin
    if (!rst || start_accept) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy_q && (perf_busy_q != '1)) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
      if (bubble && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_busy_cyc  = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;
`endif

endmodule

// File: tb/tb_sys_array_sched.sv
// Directed bench for sys_array_sched (ARRAY_N=4): table of job vectors plus reset/abort sequence.
module tb_sys_array_sched;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] n_tiles = '0;
  logic [9:0] act_len = '0;
  logic       in_stall = 1'b0;
  logic       busy, done, w_ps, w_load, act_valid, psum_capture;
  logic [1:0] w_rd_addr;
  logic [9:0] act_rd_addr;
  logic [7:0] tile_idx;
`ifdef SYS_SCHED_PERF_EN
  logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif

  sys_array_sched #(.ARRAY_N(N), .ACT_W(10), .TILE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .n_tiles(n_tiles), .act_len(act_len),
    .in_stall(in_stall), .busy(busy), .done(done), .w_ps(w_ps), .w_load(w_load),
    .act_valid(act_valid), .psum_capture(psum_capture), .w_rd_addr(w_rd_addr),
    .act_rd_addr(act_rd_addr), .tile_idx(tile_idx)
`ifdef SYS_SCHED_PERF_EN
    , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int nt;
    int al;
    bit stall;
    bit junk_start;
    int e_busy;
    int e_wl;
    int e_act;
    int e_cap;
    int e_done;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int out_word();
    return int'({busy, done, w_ps, w_load, act_valid, psum_capture, w_rd_addr, act_rd_addr, tile_idx});
  endfunction

  task automatic run_job(input vec_t v, input int id);
    int busy_c = 0, wl_c = 0, act_c = 0, cap_c = 0, done_c = 0;
    int addr_err = 0, tile_err = 0, done_err = 0, stall_err = 0;
    int cyc = 0;
    bit stalling = 1'b0;
    bit finished = 1'b0;
    logic [1:0] last_w = '0;
    logic [9:0] last_a = '0;
    start   = 1'b1;
    n_tiles = 8'(v.nt);
    act_len = 10'(v.al);
    while (cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start   = 1'b0;
        n_tiles = 8'd9;
        act_len = 10'd3;
      end
      if (stalling) begin
        if (w_load || act_valid) stall_err++;
        if (w_rd_addr != last_w || act_rd_addr != last_a) stall_err++;
      end
      if (busy) busy_c++;
      if (w_load) begin
        if (int'(w_rd_addr) != wl_c % N) addr_err++;
        if (int'(tile_idx) != wl_c / N) tile_err++;
        if (w_ps) addr_err++;
        wl_c++;
      end
      if (act_valid) begin
        if (v.al != 0 && int'(act_rd_addr) != act_c % v.al) addr_err++;
        if (!w_ps) addr_err++;
        act_c++;
      end
      if (psum_capture) cap_c++;
      if (done) begin
        done_c++;
        if (busy != (v.nt != 0)) done_err++;
      end
      last_w = w_rd_addr;
      last_a = act_rd_addr;
      stalling = v.stall && ((w_load && wl_c == 1) || (act_valid && act_c == 2));
      in_stall = stalling;
      if (v.junk_start) start = (cyc == 6);
      if (done_c > 0 && !busy && !done) begin
        finished = 1'b1;
        break;
      end
    end
    in_stall = 1'b0;
    start    = 1'b0;
    $display("job %0d n_tiles=%0d act_len=%0d stall=%0d busy=%0d w_load=%0d act_valid=%0d capture=%0d done=%0d",
             id, v.nt, v.al, v.stall, busy_c, wl_c, act_c, cap_c, done_c);
    chk("job_finished", int'(finished), 1);
    chk("busy_cycles", busy_c, v.e_busy);
    chk("w_load_cycles", wl_c, v.e_wl);
    chk("act_valid_cycles", act_c, v.e_act);
    chk("capture_cycles", cap_c, v.e_cap);
    chk("done_pulses", done_c, v.e_done);
    chk("addr_path_errs", addr_err, 0);
    chk("tile_idx_errs", tile_err, 0);
    chk("done_busy_errs", done_err, 0);
    chk("stall_errs", stall_err, 0);
`ifdef SYS_SCHED_PERF_EN
    chk("perf_busy", int'(perf_busy_cyc), v.e_busy);
    chk("perf_stall", int'(perf_stall_cyc), v.stall ? 2 : 0);
`endif
  endtask

  initial begin
    int hit;
    int bad;
    vecs[0] = '{nt: 1,   al: 8, stall: 0, junk_start: 0, e_busy: 20,   e_wl: 4,    e_act: 8,   e_cap: 4,    e_done: 1};
    vecs[1] = '{nt: 3,   al: 2, stall: 0, junk_start: 0, e_busy: 40,   e_wl: 12,   e_act: 6,   e_cap: 12,   e_done: 1};
    vecs[2] = '{nt: 1,   al: 8, stall: 1, junk_start: 0, e_busy: 22,   e_wl: 4,    e_act: 8,   e_cap: 4,    e_done: 1};
    vecs[3] = '{nt: 0,   al: 5, stall: 0, junk_start: 0, e_busy: 0,    e_wl: 0,    e_act: 0,   e_cap: 0,    e_done: 1};
    vecs[4] = '{nt: 1,   al: 0, stall: 0, junk_start: 0, e_busy: 12,   e_wl: 4,    e_act: 0,   e_cap: 4,    e_done: 1};
    vecs[5] = '{nt: 2,   al: 1, stall: 0, junk_start: 1, e_busy: 25,   e_wl: 8,    e_act: 2,   e_cap: 8,    e_done: 1};
    vecs[6] = '{nt: 255, al: 1, stall: 0, junk_start: 0, e_busy: 3061, e_wl: 1020, e_act: 255, e_cap: 1020, e_done: 1};

    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("reset outputs word=%0d", out_word());
    chk("reset_outputs", out_word(), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i], i);
      @(negedge clk);
    end

    // Abort a multi-tile job with reset while tile 1 is streaming activations.
    start   = 1'b1;
    n_tiles = 8'd3;
    act_len = 10'd4;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      if (act_valid && tile_idx == 8'd1) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_tile1_compute", hit, 1);
    rst = 1'b0;
    @(negedge clk);
    $display("abort outputs word=%0d", out_word());
    chk("abort_outputs", out_word(), 0);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy || done) bad++;
    end
    $display("post-abort quiet cycles bad=%0d", bad);
    chk("post_abort_quiet", bad, 0);

    run_job(vecs[0], 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
